// File: rtl/fifo_pkg.sv
// Shared widths, default thresholds and parameter checks for the threshold FIFO.
package fifo_pkg;

    localparam int unsigned DefaultAeThr = 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned af_thr_default(input int unsigned depth);
        return (depth > 2) ? depth - 2 : 1;
    endfunction

    function automatic bit params_ok(input int unsigned depth, input int unsigned af_thr,
                                     input int unsigned ae_thr);
        return (depth >= 2) && (af_thr >= 1) && (af_thr <= depth) && (ae_thr <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port; the array has no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset so rd_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with occupancy count and almost-full/almost-empty thresholds.
// Sticky ovf/udf error flags are built only when FIFO_ERR_EN is defined.
module sync_fifo_thr
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THR     = af_thr_default(DEPTH),
    parameter int unsigned AE_THR     = DefaultAeThr
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_ready,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_val,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    input  logic                        err_clr,
    output logic                        ovf,
    output logic                        udf
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    if (!params_ok(DEPTH, AF_THR, AE_THR)) begin : g_bad_params
        $error("sync_fifo_thr: illegal DEPTH/AF_THR/AE_THR combination");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          af_q, af_d, ae_q, ae_d;
    logic          rd_val_q, rd_val_d;
    logic          wr_acc, rd_acc;

    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_val_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        // Flags derive from the next count so they stay coherent with count.
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THR));
        ae_d    = (count_d <= CW'(AE_THR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            rd_val_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            rd_val_q <= rd_val_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

`ifdef FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A new error in the same cycle as err_clr wins.
    always_comb begin
        ovf_d = (wr_en && full_q) || (ovf_q && !err_clr);
        udf_d = (rd_en && empty_q && !wr_en) || (udf_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = err_clr & 1'b0;
    assign udf = err_clr & 1'b0;
`endif

    assign wr_ready     = !full_q;
    assign rd_val       = rd_val_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed scoreboard bench for sync_fifo_thr (DEPTH=4, AF_THR=3, AE_THR=1).
module tb_sync_fifo_thr;

`ifdef FIFO_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif
    localparam int Depth = 4;
    localparam int AfThr = 3;
    localparam int AeThr = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_val;
    logic [2:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       err_clr = 1'b0;
    logic       ovf, udf;

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];  // model storage
    logic [7:0] sb[$];  // expected read words
    logic [7:0] m_rd = '0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_thr #(
        .DATA_WIDTH (8),
        .DEPTH      (Depth),
        .AF_THR     (AfThr),
        .AE_THR     (AeThr)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_val       (rd_val),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err_clr      (err_clr),
        .ovf          (ovf),
        .udf          (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit racc);
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == Depth));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AfThr));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AeThr));
        chk("wr_ready", 32'(wr_ready), 32'(n != Depth));
        chk("rd_val", 32'(rd_val), 32'(racc));
        if (racc) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underrun", 32'(1), 32'(0));
            end else begin
                m_rd = sb.pop_front();
            end
        end
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit racc, wacc, ovf_set, udf_set;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        err_clr = clr;
        racc    = rd && (mq.size() > 0);
        wacc    = wr && (mq.size() < Depth);
        ovf_set = wr && (mq.size() == Depth);
        udf_set = rd && (mq.size() == 0) && !wr;
        if (racc) sb.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        if (ErrEn) begin
            m_ovf = ovf_set || (m_ovf && !clr);
            m_udf = udf_set || (m_udf && !clr);
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_all(racc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        sb.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_all(1'b0);
    endtask

    initial begin
        #2;
        do_reset();

        // Fill: 0x11..0x44, then a write to a full FIFO.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);

        // Wrap-around with alternating write/read.
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i), 0, 0);
            step(0, 8'h00, 1, 0);
        end

        // Simultaneous read/write at count=2.
        step(1, 8'hA0, 0, 0);
        step(1, 8'hA1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 8'hB0 + 8'(i), 1, 0);
        end
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);

        // Empty with both: write accepted, read ignored, no udf.
        step(1, 8'hC0, 1, 0);
        step(0, 8'h00, 1, 0);

        // Full with both: read accepted, write dropped.
        step(1, 8'hD0, 0, 0);
        step(1, 8'hD1, 0, 0);
        step(1, 8'hD2, 0, 0);
        step(1, 8'hD3, 0, 0);
        step(1, 8'hEE, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Reads from empty, then clear, then clear colliding with a new underflow.
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 0);

        // Reset mid-stream at count=3.
        step(1, 8'h61, 0, 0);
        step(1, 8'h62, 1, 0);
        step(1, 8'h63, 0, 0);
        step(1, 8'h64, 0, 0);
        do_reset();
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
